// File: rtl/ccode_unit.sv
// Condition-code unit: NVZ flag register with masked writes, shadow save/restore,
// one-cycle branch condition evaluation and a wrapping taken-branch counter.
module ccode_unit #(
  parameter int DATA_W = 16,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [2:0]        wr_mask,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_ovfl,
  input  logic              br_valid,
  input  logic [2:0]        br_cond,
  input  logic              stall,
  input  logic              flush,
  input  logic              save,
  input  logic              restore,
  output logic [2:0]        flags,
  output logic              taken,
  output logic              taken_valid,
  output logic [CNT_W-1:0]  taken_cnt
);

  logic [2:0]       r_flags;
  logic [2:0]       r_shadow;
  logic             r_taken;
  logic             r_taken_valid;
  logic [CNT_W-1:0] r_taken_cnt;

  logic [2:0] w_new_flags;
  logic [2:0] w_merged;
  logic [2:0] w_eval_flags;
  logic       w_wr;
  logic       w_tv;
  logic       w_tk;

  // Condition table, flag vector is {N, V, Z}
  function automatic logic f_cond(input logic [2:0] c, input logic [2:0] f);
    logic n, v, z;
    n = f[2];
    v = f[1];
    z = f[0];
    case (c)
      3'b000:  f_cond = ~z;
      3'b001:  f_cond = z;
      3'b010:  f_cond = ~z & ~n;
      3'b011:  f_cond = n;
      3'b100:  f_cond = z | ~n;
      3'b101:  f_cond = z | n;
      3'b110:  f_cond = v;
      default: f_cond = 1'b1;
    endcase
  endfunction

  assign w_new_flags  = {alu_out[DATA_W-1], alu_ovfl, ~|alu_out};
  assign w_wr         = wr_valid & ~stall;
  assign w_merged     = (w_new_flags & wr_mask) | (r_flags & ~wr_mask);
  assign w_eval_flags = ((BYPASS != 0) && w_wr) ? w_merged : r_flags;
  assign w_tv         = br_valid & ~stall & ~flush;
  assign w_tk         = w_tv & f_cond(br_cond, w_eval_flags);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags       <= 3'b000;
      r_shadow      <= 3'b000;
      r_taken       <= 1'b0;
      r_taken_valid <= 1'b0;
      r_taken_cnt   <= '0;
    end else begin
      r_taken_valid <= w_tv;
      r_taken       <= w_tk;
      if (!stall) begin
        // Restore wins over a same-cycle write; save captures pre-write flags
        if (restore) begin
          r_flags <= r_shadow;
        end else if (wr_valid) begin
          r_flags <= w_merged;
        end
        if (save && !restore) begin
          r_shadow <= r_flags;
        end
        if (w_tk) begin
          r_taken_cnt <= r_taken_cnt + 1'b1;
        end
      end
    end
  end

  assign flags       = r_flags;
  assign taken       = r_taken;
  assign taken_valid = r_taken_valid;
  assign taken_cnt   = r_taken_cnt;

endmodule

// File: tb/tb_ccode_unit.sv
// Scoreboard bench for ccode_unit: two instances (bypass/16-bit and stored-only/32-bit)
// driven by directed then random stimulus and checked against a flag-level model.
module tb_ccode_unit;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic [2:0]  wr_mask;
  logic [31:0] alu_out;
  logic        alu_ovfl;
  logic        br_valid;
  logic [2:0]  br_cond;
  logic        stall;
  logic        flush;
  logic        save;
  logic        restore;

  logic [2:0]  flags_a, flags_b;
  logic        taken_a, taken_b, tv_a, tv_b;
  logic [2:0]  cnt_a;
  logic [1:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  ccode_unit #(.DATA_W(16), .BYPASS(1), .CNT_W(3)) u_a (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_mask(wr_mask),
    .alu_out(alu_out[15:0]), .alu_ovfl(alu_ovfl), .br_valid(br_valid),
    .br_cond(br_cond), .stall(stall), .flush(flush), .save(save),
    .restore(restore), .flags(flags_a), .taken(taken_a),
    .taken_valid(tv_a), .taken_cnt(cnt_a)
  );

  ccode_unit #(.DATA_W(32), .BYPASS(0), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_mask(wr_mask),
    .alu_out(alu_out), .alu_ovfl(alu_ovfl), .br_valid(br_valid),
    .br_cond(br_cond), .stall(stall), .flush(flush), .save(save),
    .restore(restore), .flags(flags_b), .taken(taken_b),
    .taken_valid(tv_b), .taken_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int fa; int tva; int tka; int ca;
    int fb; int tvb; int tkb; int cb;
  } exp_t;

  exp_t sbq[$];

  // Reference state per instance: index 0 = bypass/16-bit, 1 = stored-only/32-bit
  int m_n[2], m_v[2], m_z[2];
  int s_n[2], s_v[2], s_z[2];
  int m_cnt[2];
  int m_tv[2], m_tk[2];
  int cnt_mod[2] = '{8, 4};
  int bypass[2]  = '{1, 0};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int cond_ok(input int c, input int n, input int v, input int z);
    case (c)
      0: return (z == 0);
      1: return (z == 1);
      2: return (z == 0 && n == 0);
      3: return (n == 1);
      4: return (z == 1 || n == 0);
      5: return (z == 1 || n == 1);
      6: return (v == 1);
      default: return 1;
    endcase
  endfunction

  function automatic int fvec(input int n, input int v, input int z);
    return n * 4 + v * 2 + z;
  endfunction

  task automatic push_expected();
    exp_t e;
    e.fa = fvec(m_n[0], m_v[0], m_z[0]); e.tva = m_tv[0]; e.tka = m_tk[0]; e.ca = m_cnt[0];
    e.fb = fvec(m_n[1], m_v[1], m_z[1]); e.tvb = m_tv[1]; e.tkb = m_tk[1]; e.cb = m_cnt[1];
    sbq.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_n[i] = 0; m_v[i] = 0; m_z[i] = 0;
      s_n[i] = 0; s_v[i] = 0; s_z[i] = 0;
      m_cnt[i] = 0; m_tv[i] = 0; m_tk[i] = 0;
    end
  endtask

  task automatic drive(input int wr, input int mask, input logic [31:0] alu, input int ovfl,
                       input int br, input int cond, input int st, input int fl,
                       input int sv, input int rs);
    int nn, nz, wn, wv, wz, en, ev, ez;
    @(negedge clk);
    rst      = 1'b0;
    wr_valid = wr[0];
    wr_mask  = mask[2:0];
    alu_out  = alu;
    alu_ovfl = ovfl[0];
    br_valid = br[0];
    br_cond  = cond[2:0];
    stall    = st[0];
    flush    = fl[0];
    save     = sv[0];
    restore  = rs[0];
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        nn = int'(alu[15]);
        nz = (alu[15:0] == 16'd0) ? 1 : 0;
      end else begin
        nn = int'(alu[31]);
        nz = (alu == 32'd0) ? 1 : 0;
      end
      wn = mask[2] ? nn   : m_n[i];
      wv = mask[1] ? ovfl : m_v[i];
      wz = mask[0] ? nz   : m_z[i];
      if (bypass[i] == 1 && wr == 1 && st == 0) begin
        en = wn; ev = wv; ez = wz;
      end else begin
        en = m_n[i]; ev = m_v[i]; ez = m_z[i];
      end
      m_tv[i] = (br == 1 && st == 0 && fl == 0) ? 1 : 0;
      m_tk[i] = (m_tv[i] == 1) ? cond_ok(cond, en, ev, ez) : 0;
      if (st == 0) begin
        if (rs == 1) begin
          m_n[i] = s_n[i]; m_v[i] = s_v[i]; m_z[i] = s_z[i];
        end else begin
          if (sv == 1) begin
            s_n[i] = m_n[i]; s_v[i] = m_v[i]; s_z[i] = m_z[i];
          end
          if (wr == 1) begin
            m_n[i] = wn; m_v[i] = wv; m_z[i] = wz;
          end
        end
        if (m_tk[i] == 1) m_cnt[i] = (m_cnt[i] + 1) % cnt_mod[i];
      end
    end
    push_expected();
  endtask

  task automatic idle();
    drive(0, 0, 32'd0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset asserted between edges must clear outputs without waiting for a clock
  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    wr_valid = 1'b0; br_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    save = 1'b0; restore = 1'b0;
    #1;
    chk("async_rst_flags_a", int'(flags_a), 0);
    chk("async_rst_tv_a",    int'(tv_a),    0);
    chk("async_rst_taken_a", int'(taken_a), 0);
    chk("async_rst_cnt_a",   int'(cnt_a),   0);
    chk("async_rst_flags_b", int'(flags_b), 0);
    chk("async_rst_cnt_b",   int'(cnt_b),   0);
    model_reset();
    push_expected();
  endtask

  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("flags_a",       int'(flags_a), e.fa);
      chk("taken_valid_a", int'(tv_a),    e.tva);
      chk("taken_a",       int'(taken_a), e.tka);
      chk("taken_cnt_a",   int'(cnt_a),   e.ca);
      chk("flags_b",       int'(flags_b), e.fb);
      chk("taken_valid_b", int'(tv_b),    e.tvb);
      chk("taken_b",       int'(taken_b), e.tkb);
      chk("taken_cnt_b",   int'(cnt_b),   e.cb);
    end
  end

  initial begin
    rst = 1'b1;
    wr_valid = 1'b0; wr_mask = 3'b000; alu_out = 32'd0; alu_ovfl = 1'b0;
    br_valid = 1'b0; br_cond = 3'b000; stall = 1'b0; flush = 1'b0;
    save = 1'b0; restore = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_flags_a", int'(flags_a), 0);
    chk("init_tv_a",    int'(tv_a),    0);
    chk("init_cnt_b",   int'(cnt_b),   0);

    // Branches on reset flags, then same-cycle Z write with bypass vs stored
    drive(0, 0, 32'd0, 0, 1, 1, 0, 0, 0, 0);
    drive(0, 0, 32'd0, 0, 1, 7, 0, 0, 0, 0);
    drive(1, 1, 32'd0, 0, 1, 1, 0, 0, 0, 0);
    idle();
    // N and V set from a negative overflowing result
    drive(1, 7, 32'h8000_8000, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 32'd0, 0, 1, 3, 0, 0, 0, 0);
    drive(0, 0, 32'd0, 0, 1, 6, 0, 0, 0, 0);
    drive(0, 0, 32'd0, 0, 1, 2, 0, 0, 0, 0);
    // Save/restore with restore beating a full write
    drive(1, 7, 32'd0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 32'd0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 7, 32'h8000_8000, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 7, 32'h0000_0001, 1, 0, 0, 0, 0, 0, 1);
    // Save alongside a write captures pre-write flags
    drive(1, 7, 32'h8000_8000, 1, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 32'd0, 0, 0, 0, 0, 0, 0, 1);
    // Stall freezes everything, flush only drops the branch
    drive(1, 7, 32'h8000_8000, 1, 1, 7, 1, 0, 1, 0);
    drive(1, 7, 32'h8000_8000, 1, 1, 7, 0, 1, 0, 0);
    // Counter wrap, then reset mid-sequence
    repeat (5) drive(0, 0, 32'd0, 0, 1, 7, 0, 0, 0, 0);
    reset_pulse();
    drive(0, 0, 32'd0, 0, 0, 7, 0, 0, 0, 0);
    drive(0, 0, 32'd0, 0, 1, 7, 0, 0, 0, 0);
    // Reset while a branch result is pending
    drive(0, 0, 32'd0, 0, 1, 7, 0, 0, 0, 0);
    reset_pulse();
    idle();

    for (int k = 0; k < 3000; k++) begin
      logic [31:0] a;
      a = $urandom();
      case ($urandom_range(0, 3))
        0: a = 32'd0;
        1: a = a & 32'h0000_ffff;
        2: a = a & 32'hffff_0000;
        default: ;
      endcase
      if ($urandom_range(0, 199) == 0) begin
        reset_pulse();
      end else begin
        drive(($urandom_range(0, 1)), $urandom_range(0, 7), a, $urandom_range(0, 1),
              ($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 7),
              ($urandom_range(0, 7) == 0) ? 1 : 0, ($urandom_range(0, 7) == 0) ? 1 : 0,
              ($urandom_range(0, 9) == 0) ? 1 : 0, ($urandom_range(0, 9) == 0) ? 1 : 0);
      end
    end
    idle();
    @(posedge clk);
    #2;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
